// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between the instruction-fetch stage and the
// load/store (EX) stage. Only one access is in flight at a time; each access
// walks IDLE -> FETCH/DATA -> RESP -> IDLE. Data accesses normally win
// contention, but a streak counter forces a fetch grant once STARVE_LIMIT
// data grants have been made in a row while a fetch was waiting.
//
// Parameters
//   STARVE_LIMIT  max consecutive data grants while a fetch waits
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   i_req/i_addr  fetch request and pc (held until i_done)
//   i_flush       branch kill of an outstanding fetch (drops its i_done)
//   i_done        one-cycle fetch completion pulse, i_rdata valid with it
//   d_req/d_we    load/store request (held until d_done), 1 = store
//   d_addr        data address
//   d_wdata       store data
//   d_done        one-cycle data completion pulse, d_rdata valid with it
//   mem_req       registered memory request
//   mem_we        registered memory write enable
//   mem_addr      registered memory address
//   mem_wdata     registered memory write data
//   mem_ready     memory completes the current access this cycle
//   mem_rdata     memory read data, valid with mem_ready
//   stall         pipeline stall while a request waits for its done
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_done,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,

    output logic        stall
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Wide enough to hold STARVE_LIMIT; at least one bit so a limit of 0
    // still elaborates (it then always favours the fetch).
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [1:0]          state;
    logic [STREAK_W-1:0] streak;
    logic                flush_seen;
    logic                i_done_q;
    logic                grant_fetch;
    logic                grant_data;

    // Arbitration decision, only meaningful in IDLE. Data wins unless the
    // fetch has already been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state == IDLE) begin
            if (d_req && !(i_req && (streak == STREAK_MAX))) begin
                grant_data = 1'b1;
            end else if (i_req) begin
                grant_fetch = 1'b1;
            end
        end
    end

    // Main transaction sequencer. The mem_* outputs are loaded on the grant
    // edge and then left untouched until the memory answers, so the memory
    // sees a stable request for however long it takes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            streak     <= '0;
            flush_seen <= 1'b0;
            i_done_q   <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // Only data grants that overtake a waiting fetch count.
                        if (i_req && (streak != STREAK_MAX)) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (grant_fetch) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= i_addr;
                        streak   <= '0;
                    end
                end

                FETCH: begin
                    if (i_flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (mem_ready) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        i_rdata  <= mem_rdata[31:0];
                        // A flush seen on this very edge counts as well.
                        i_done_q <= !(flush_seen || i_flush);
                    end
                end

                DATA: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_done  <= 1'b1;
                    end
                end

                RESP: begin
                    state      <= IDLE;
                    i_done_q   <= 1'b0;
                    d_done     <= 1'b0;
                    flush_seen <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A flush arriving during the RESP cycle itself must still kill the
    // pulse, so the registered pulse is gated by the live flush input.
    assign i_done = i_done_q && !i_flush;

    // A requester is stalled while its request is up and its own done is not.
    assign stall = (i_req && !i_done) || (d_req && !d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A per-cycle vector table covers reset,
// a single-cycle load, a wait-state store, a flushed fetch followed by a
// normal fetch, and reset in the middle of a data access. Hand-written
// sequences then cover sustained contention (starvation limit) and
// back-to-back data requests.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        stall;

    int total  = 0;
    int passed = 0;

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // One record per clock cycle: inputs driven in that cycle and outputs
    // expected during that same cycle. Wide fields are checked only when
    // their chk_* flag is set.
    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        i_flush;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [63:0] d_wdata;
        logic        mem_ready;
        logic [63:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic        e_i_done;
        logic        e_d_done;
        logic        e_stall;
        logic        chk_addr;
        logic [31:0] e_mem_addr;
        logic        chk_wdata;
        logic [63:0] e_mem_wdata;
        logic        chk_irdata;
        logic [31:0] e_i_rdata;
        logic        chk_drdata;
        logic [63:0] e_d_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic ireq, input logic [31:0] iaddr,
                                input logic iflush, input logic dreq, input logic dwe,
                                input logic [31:0] daddr, input logic [63:0] dwdata,
                                input logic mrdy, input logic [63:0] mrdata,
                                input logic ereq, input logic ewe, input logic eidone,
                                input logic eddone, input logic estall);
        vec_t v;
        v.rst = r;          v.i_req = ireq;     v.i_addr = iaddr;    v.i_flush = iflush;
        v.d_req = dreq;     v.d_we = dwe;       v.d_addr = daddr;    v.d_wdata = dwdata;
        v.mem_ready = mrdy; v.mem_rdata = mrdata;
        v.e_mem_req = ereq; v.e_mem_we = ewe;   v.e_i_done = eidone; v.e_d_done = eddone;
        v.e_stall = estall;
        v.chk_addr = 1'b0;   v.e_mem_addr = '0;
        v.chk_wdata = 1'b0;  v.e_mem_wdata = '0;
        v.chk_irdata = 1'b0; v.e_i_rdata = '0;
        v.chk_drdata = 1'b0; v.e_d_rdata = '0;
        return v;
    endfunction

    function automatic vec_t with_addr(input vec_t v, input logic [31:0] a);
        vec_t r = v;
        r.chk_addr = 1'b1;
        r.e_mem_addr = a;
        return r;
    endfunction

    function automatic vec_t with_wdata(input vec_t v, input logic [63:0] w);
        vec_t r = v;
        r.chk_wdata = 1'b1;
        r.e_mem_wdata = w;
        return r;
    endfunction

    function automatic vec_t with_irdata(input vec_t v, input logic [31:0] d);
        vec_t r = v;
        r.chk_irdata = 1'b1;
        r.e_i_rdata = d;
        return r;
    endfunction

    function automatic vec_t with_drdata(input vec_t v, input logic [63:0] d);
        vec_t r = v;
        r.chk_drdata = 1'b1;
        r.e_d_rdata = d;
        return r;
    endfunction

    // Every output at its reset value.
    function automatic vec_t all_zero(input vec_t v);
        return with_drdata(with_irdata(with_wdata(with_addr(v, '0), '0), '0), '0);
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        i_req     = v.i_req;
        i_addr    = v.i_addr;
        i_flush   = v.i_flush;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_ready = v.mem_ready;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        check_val($sformatf("row%0d mem_req", idx), mem_req, v.e_mem_req);
        check_val($sformatf("row%0d mem_we", idx), mem_we, v.e_mem_we);
        check_val($sformatf("row%0d i_done", idx), i_done, v.e_i_done);
        check_val($sformatf("row%0d d_done", idx), d_done, v.e_d_done);
        check_val($sformatf("row%0d stall", idx), stall, v.e_stall);
        if (v.chk_addr)   check_val($sformatf("row%0d mem_addr", idx), mem_addr, v.e_mem_addr);
        if (v.chk_wdata)  check_val($sformatf("row%0d mem_wdata", idx), mem_wdata, v.e_mem_wdata);
        if (v.chk_irdata) check_val($sformatf("row%0d i_rdata", idx), i_rdata, v.e_i_rdata);
        if (v.chk_drdata) check_val($sformatf("row%0d d_rdata", idx), d_rdata, v.e_d_rdata);
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] LD = 64'h1122334455667788;

    initial begin
        bit is_fetch;

        rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        //                  rst ireq iaddr   fl dreq we daddr    dwdata       rdy rdata                      req we id dd st
        // reset and idle
        vecs.push_back(all_zero(mk(1, 0, 32'h0,  0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 0));
        // load, memory answers in the first cycle
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 32'h100, 64'h0,        0, 64'h0,                   0, 0, 0, 0, 1));
        vecs.push_back(with_addr(mk(0, 0, 32'h0, 0, 1, 0, 32'h100, 64'h0, 1, LD,                    1, 0, 0, 0, 1), 32'h100));
        vecs.push_back(with_drdata(mk(0, 0, 32'h0, 0, 1, 0, 32'h100, 64'h0, 0, 64'h0,               0, 0, 0, 1, 0), LD));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 0));
        // store with three memory cycles; late address/data changes are ignored
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 32'h200, 64'hDEADBEEF, 0, 64'h0,                   0, 0, 0, 0, 1));
        vecs.push_back(with_wdata(with_addr(mk(0, 0, 32'h0, 0, 1, 1, 32'h200, 64'hDEADBEEF, 0, 64'h0, 1, 1, 0, 0, 1), 32'h200), 64'hDEADBEEF));
        vecs.push_back(with_wdata(with_addr(mk(0, 0, 32'h0, 0, 1, 1, 32'h204, 64'hCAFE, 0, 64'h0,     1, 1, 0, 0, 1), 32'h200), 64'hDEADBEEF));
        vecs.push_back(with_wdata(with_addr(mk(0, 0, 32'h0, 0, 1, 1, 32'h204, 64'hCAFE, 1, 64'h9999,  1, 1, 0, 0, 1), 32'h200), 64'hDEADBEEF));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 32'h204, 64'hCAFE,     0, 64'h0,                   0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 0));
        // fetch 0x40 flushed in its mem_req cycle, then fetch 0x80 completes
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 1));
        vecs.push_back(with_addr(mk(0, 1, 32'h40, 1, 0, 0, 32'h0, 64'h0, 1, 64'hAAAABBBB12345678,    1, 0, 0, 0, 1), 32'h40));
        vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 1));
        vecs.push_back(with_addr(mk(0, 1, 32'h80, 0, 0, 0, 32'h0, 64'h0, 1, 64'hFFFF000000000013,    1, 0, 0, 0, 1), 32'h80));
        vecs.push_back(with_irdata(mk(0, 1, 32'h80, 0, 0, 0, 32'h0, 64'h0, 0, 64'h0,                0, 0, 1, 0, 0), 32'h13));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0,   64'h0,        0, 64'h0,                   0, 0, 0, 0, 0));
        // both requesting, data granted, then reset with mem_ready in the DATA cycle
        vecs.push_back(mk(0, 1, 32'h1000, 0, 1, 0, 32'h300, 64'h77,     0, 64'h0,                   0, 0, 0, 0, 1));
        vecs.push_back(with_wdata(with_addr(mk(1, 1, 32'h1000, 0, 1, 0, 32'h300, 64'h77, 1, 64'h55,  1, 0, 0, 0, 1), 32'h300), 64'h77));
        vecs.push_back(all_zero(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0,  0, 64'h0,                   0, 0, 0, 0, 0)));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i]);
            next_cycle();
        end

        // Sustained contention straight after reset: the streak must start
        // from zero, giving D,D,D,F,D,D,D,F.
        $display("[TB] contention sequence");
        rst = 1'b0; i_flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0;
        for (int g = 0; g < 8; g++) begin
            is_fetch = ((g % 4) == 3);
            next_cycle();
            check_val($sformatf("grant%0d mem_req", g), mem_req, 1'b1);
            check_val($sformatf("grant%0d mem_addr", g), mem_addr, is_fetch ? 32'h1000 : 32'h2000);
            mem_ready = 1'b1;
            mem_rdata = 64'h100 + 64'(g);
            next_cycle();
            mem_ready = 1'b0;
            #1;
            check_val($sformatf("grant%0d i_done", g), i_done, is_fetch);
            check_val($sformatf("grant%0d d_done", g), d_done, !is_fetch);
            if (is_fetch) check_val($sformatf("grant%0d i_rdata", g), i_rdata, 32'h100 + 32'(g));
            else          check_val($sformatf("grant%0d d_rdata", g), d_rdata, 64'h100 + 64'(g));
            next_cycle();
        end

        // Back-to-back loads: one IDLE cycle between RESP and the next mem_req.
        $display("[TB] back-to-back sequence");
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        check_val("b2b idle stall", stall, 1'b1);
        check_val("b2b idle mem_req", mem_req, 1'b0);
        next_cycle();
        check_val("b2b first mem_req", mem_req, 1'b1);
        check_val("b2b first mem_addr", mem_addr, 32'h100);
        check_val("b2b first stall", stall, 1'b1);
        mem_ready = 1'b1; mem_rdata = 64'hA1A1;
        next_cycle();
        mem_ready = 1'b0; d_addr = 32'h108;
        #1;
        check_val("b2b first d_done", d_done, 1'b1);
        check_val("b2b first d_rdata", d_rdata, 64'hA1A1);
        check_val("b2b first resp stall", stall, 1'b0);
        check_val("b2b resp mem_req", mem_req, 1'b0);
        next_cycle();
        check_val("b2b gap mem_req", mem_req, 1'b0);
        check_val("b2b gap d_done", d_done, 1'b0);
        check_val("b2b gap stall", stall, 1'b1);
        next_cycle();
        check_val("b2b second mem_req", mem_req, 1'b1);
        check_val("b2b second mem_addr", mem_addr, 32'h108);
        check_val("b2b second stall", stall, 1'b1);
        mem_ready = 1'b1; mem_rdata = 64'hB2B2;
        next_cycle();
        mem_ready = 1'b0;
        #1;
        check_val("b2b second d_done", d_done, 1'b1);
        check_val("b2b second d_rdata", d_rdata, 64'hB2B2);
        check_val("b2b second resp stall", stall, 1'b0);
        d_req = 1'b0;
        next_cycle();
        check_val("b2b end stall", stall, 1'b0);
        check_val("b2b end d_done", d_done, 1'b0);
        check_val("b2b end mem_req", mem_req, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum number of consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req  input  1  fetch request; held until i_done.
REQ-005 SHALL have port i_addr  input  32  fetch address (pc).
REQ-006 SHALL have port i_flush  input  1  branch-taken kill of an outstanding fetch.
REQ-007 SHALL have port i_done  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port i_rdata  output  32  fetched instruction; valid while i_done=1.
REQ-009 SHALL have port d_req  input  1  load/store request from EX; held until d_done.
REQ-010 SHALL have port d_we  input  1  0 = load (read), 1 = store (write); matches the EX mem_rw encoding.
REQ-011 SHALL have port d_addr  input  32  data address (EX result[31:0]).
REQ-012 SHALL have port d_wdata  input  64  store data.
REQ-013 SHALL have port d_done  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port d_rdata  output  64  load data; valid while d_done=1.
REQ-015 SHALL have port mem_req  output  1  memory request, registered.
REQ-016 SHALL have port mem_we  output  1  memory write enable, registered.
REQ-017 SHALL have port mem_addr  output  32  memory address, registered.
REQ-018 SHALL have port mem_wdata  output  64  memory write data, registered.
REQ-019 SHALL have port mem_ready  input  1  memory completes the current access in this cycle.
REQ-020 SHALL have port mem_rdata  input  64  read data; valid when mem_ready=1.
REQ-021 SHALL have port stall  output  1  pipeline stall; high when (i_req or d_req) and the matching done is not asserted this cycle.

Function
REQ-022 SHALL implement FSM states IDLE, FETCH, DATA and RESP.
REQ-023 In IDLE, SHALL grant on the edge as follows: d_req only -> DATA; i_req only -> FETCH; both asserted -> DATA, unless streak==STARVE_LIMIT, in which case -> FETCH; neither -> stay in IDLE.
REQ-024 On grant, SHALL latch the winner's address (and, for data, d_we and d_wdata) into mem_addr/mem_we/mem_wdata, and SHALL assert mem_req from the next cycle; mem_we SHALL be 0 for fetch.
REQ-025 In FETCH/DATA, SHALL hold mem_req=1 and all mem_* outputs stable until a cycle with mem_ready=1.
REQ-026 On that mem_ready edge, SHALL capture mem_rdata (fetch: bits [31:0] into i_rdata; data: all 64 bits into d_rdata), drop mem_req and mem_we, and go to RESP.
REQ-027 In RESP, SHALL pulse the matching done for exactly one cycle, ignore both requests, then return to IDLE.
REQ-028 Store completion SHALL pulse d_done; d_rdata content is don't-care for stores.
REQ-029 Minimum latency SHALL be: req sampled at edge N, mem_req high in cycle N+1, mem_ready in cycle N+1, done in cycle N+2; one access every 3 cycles maximum.
REQ-030 Requester SHALL be allowed to drop req on the edge that samples done=1; the arbiter SHALL NOT re-grant a request during RESP.
REQ-031 streak counter (saturating at STARVE_LIMIT): SHALL +1 on each DATA grant made with i_req=1, SHALL clear on each FETCH grant, and SHALL be unchanged on a DATA grant with i_req=0.
REQ-032 If i_flush=1 in any cycle from the FETCH grant through RESP, the memory access SHALL still complete normally, but i_done SHALL be suppressed for that fetch; the flush is remembered until RESP.
REQ-033 i_flush SHALL have no effect on a DATA transaction or in IDLE.
REQ-034 Request changes while not in IDLE SHALL be ignored, with no re-arbitration mid-transaction.

Reset
REQ-035 On rst=1 at an edge, SHALL enter IDLE regardless of state, discarding any in-flight access, with no done pulse for it.
REQ-036 Reset values SHALL be: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, streak=0, flush flag=0.
REQ-037 mem_ready arriving in the cycle rst=1 SHALL be ignored.

Verification
REQ-038 Load: d_req=1, d_we=0, d_addr=0x100; memory answers mem_ready in 1st cycle with 0x1122334455667788 -> mem_req high 1 cycle, mem_we=0, d_done at cycle N+2, d_rdata=0x1122334455667788.
REQ-039 Store with 3-cycle memory wait: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1, addr and data stable for all 3 cycles; d_done exactly once; no i_done.
REQ-040 Contention with default parameter: i_req and d_req held high continuously (each re-raised after its done) -> grant order D,D,D,F,D,D,D,F; fetch never waits more than 3 data accesses.
REQ-041 Flush: fetch at i_addr=0x40, i_flush pulsed in the mem_req cycle -> mem access completes, i_done stays 0, FSM returns to IDLE, and the next fetch (0x80) completes normally.
REQ-042 Reset mid-access: rst asserted in the DATA state with mem_ready=1 in the same cycle -> next cycle mem_req=0, d_done=0, all outputs at reset values, streak=0.
REQ-043 Back-to-back: d_req kept high after d_done (new addr 0x108) -> second mem_req starts exactly one cycle after the RESP cycle; stall=1 in every cycle without done.
